// File: rtl/axi_dw_burst_allocator.sv
// W-channel allocator: routes N_TARG_PORT slave W inputs to one master W output
// in AW order, generates WLAST from AWLEN. Optional output slice: AXI_DW_OUT_SLICE_EN.
module axi_dw_burst_allocator #(
  parameter int unsigned N_TARG_PORT  = 7,
  parameter int unsigned AXI_DATA_W   = 64,
  parameter int unsigned AXI_USER_W   = 6,
  parameter int unsigned FIFO_DEPTH   = 8,
  parameter int unsigned LEN_W        = 8,
  parameter int unsigned AXI_NUMBYTES = AXI_DATA_W / 8,
  parameter int unsigned LOG_N_TARG   = $clog2(N_TARG_PORT)
) (
  input  logic                                  clk,
  input  logic                                  rst_n,
  input  logic [N_TARG_PORT*AXI_DATA_W-1:0]     wdata_i,
  input  logic [N_TARG_PORT*AXI_NUMBYTES-1:0]   wstrb_i,
  input  logic [N_TARG_PORT-1:0]                wlast_i,
  input  logic [N_TARG_PORT*AXI_USER_W-1:0]     wuser_i,
  input  logic [N_TARG_PORT-1:0]                wvalid_i,
  output logic [N_TARG_PORT-1:0]                wready_o,
  output logic [AXI_DATA_W-1:0]                 wdata_o,
  output logic [AXI_NUMBYTES-1:0]               wstrb_o,
  output logic [AXI_USER_W-1:0]                 wuser_o,
  output logic                                  wlast_o,
  output logic                                  wvalid_o,
  input  logic                                  wready_i,
  input  logic                                  push_id_i,
  input  logic [LOG_N_TARG-1:0]                 id_bin_i,
  input  logic [LEN_W-1:0]                      len_i,
  output logic                                  grant_fifo_id_o,
  output logic [$clog2(FIFO_DEPTH):0]           fifo_count_o,
  output logic                                  wlast_err_o
);

  localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;
  localparam int unsigned IDX_W = LOG_N_TARG + 1;

  typedef enum logic {S_IDLE, S_BURST} state_e;

  logic [LOG_N_TARG-1:0] bin_mem_q [FIFO_DEPTH];
  logic [LEN_W-1:0]      len_mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0]      wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0]      count_q;
  logic                  fifo_empty, fifo_full, push_ok, pop;
  logic [LOG_N_TARG-1:0] head_bin;
  logic [LEN_W-1:0]      head_len;

  state_e                state_q, state_d;
  logic [LEN_W-1:0]      cnt_q, cnt_d;
  logic                  err_q;

  logic                    active, up_valid, up_ready, xfer, last_c;
  logic                    sel_valid, sel_last;
  logic [AXI_DATA_W-1:0]   sel_data;
  logic [AXI_NUMBYTES-1:0] sel_strb;
  logic [AXI_USER_W-1:0]   sel_user;

  assign fifo_empty      = (count_q == '0);
  assign fifo_full       = (count_q == CNT_W'(FIFO_DEPTH));
  assign push_ok         = push_id_i & ~fifo_full;
  assign head_bin        = bin_mem_q[rd_ptr_q];
  assign head_len        = len_mem_q[rd_ptr_q];
  assign grant_fifo_id_o = ~fifo_full;
  assign fifo_count_o    = count_q;

  // ID FIFO storage; no reset needed, entries are only read when valid
  always_ff @(posedge clk) begin
    if (push_ok) begin
      bin_mem_q[wr_ptr_q] <= id_bin_i;
      len_mem_q[wr_ptr_q] <= len_i;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_ok) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (pop)     rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      case ({push_ok, pop})
        2'b10:   count_q <= count_q + CNT_W'(1);
        2'b01:   count_q <= count_q - CNT_W'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  // Source-port mux selected by the FIFO head
  always_comb begin
    sel_valid = 1'b0;
    sel_last  = 1'b0;
    sel_data  = '0;
    sel_strb  = '0;
    sel_user  = '0;
    for (int unsigned i = 0; i < N_TARG_PORT; i++) begin
      if (head_bin == LOG_N_TARG'(i)) begin
        sel_valid = wvalid_i[i];
        sel_last  = wlast_i[i];
        sel_data  = wdata_i[i*AXI_DATA_W +: AXI_DATA_W];
        sel_strb  = wstrb_i[i*AXI_NUMBYTES +: AXI_NUMBYTES];
        sel_user  = wuser_i[i*AXI_USER_W +: AXI_USER_W];
      end
    end
  end

  // Gating with rst_n keeps any handshake from completing during reset
  assign active   = rst_n & ~fifo_empty;
  assign up_valid = active & sel_valid;
  assign xfer     = up_valid & up_ready;
  assign last_c   = (cnt_q == head_len);
  assign pop      = xfer & last_c;

  always_comb begin
    for (int unsigned i = 0; i < N_TARG_PORT; i++) begin
      wready_o[i] = active & up_ready & (head_bin == LOG_N_TARG'(i));
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      err_q   <= xfer & (sel_last != last_c);
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_IDLE: begin
        if (xfer && !last_c) begin
          cnt_d   = cnt_q + LEN_W'(1);
          state_d = S_BURST;
        end
      end
      S_BURST: begin
        if (xfer) begin
          if (last_c) begin
            cnt_d   = '0;
            state_d = S_IDLE;
          end else begin
            cnt_d   = cnt_q + LEN_W'(1);
          end
        end
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  assign wlast_err_o = err_q;

`ifdef AXI_DW_OUT_SLICE_EN
  localparam int unsigned PL_W = AXI_DATA_W + AXI_NUMBYTES + AXI_USER_W + 1;

  logic [PL_W-1:0] sl_mem_q [2];
  logic            sl_wr_q, sl_rd_q;
  logic [1:0]      sl_cnt_q;
  logic            sl_pop;

  // Two-entry slice: upstream ready depends only on free space
  assign up_ready = (sl_cnt_q != 2'd2);
  assign wvalid_o = (sl_cnt_q != 2'd0);
  assign sl_pop   = wvalid_o & wready_i;
  assign {wdata_o, wstrb_o, wuser_o, wlast_o} = sl_mem_q[sl_rd_q];

  always_ff @(posedge clk) begin
    if (xfer) sl_mem_q[sl_wr_q] <= {sel_data, sel_strb, sel_user, last_c};
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sl_wr_q  <= 1'b0;
      sl_rd_q  <= 1'b0;
      sl_cnt_q <= 2'd0;
    end else begin
      if (xfer)   sl_wr_q <= ~sl_wr_q;
      if (sl_pop) sl_rd_q <= ~sl_rd_q;
      case ({xfer, sl_pop})
        2'b10:   sl_cnt_q <= sl_cnt_q + 2'd1;
        2'b01:   sl_cnt_q <= sl_cnt_q - 2'd1;
        default: sl_cnt_q <= sl_cnt_q;
      endcase
    end
  end
`else
  assign up_ready = wready_i;
  assign wvalid_o = up_valid;
  assign wdata_o  = sel_data;
  assign wstrb_o  = sel_strb;
  assign wuser_o  = sel_user;
  assign wlast_o  = last_c;
`endif

  always_ff @(posedge clk) begin
    if (rst_n && push_id_i) begin
      assert ({1'b0, id_bin_i} < IDX_W'(N_TARG_PORT))
        else $error("id_bin_i out of range");
    end
  end

endmodule
